// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, oversampling frame FSM with framing/break handling, show-ahead FIFO.
// Define UART_RX_PARITY_EN to receive and check an even parity bit after the data bits.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_serial,
  input  logic                          rx_ready,
  input  logic                          err_clear,
  output logic                          rx_valid,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic [DATA_BITS-1:0]          last_byte,
  output logic                          byte_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_error,
  output logic                          parity_error
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned LAST  = CLKS_PER_BIT - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, rxs_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 good_c, ferr_c;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_c;
  logic                 parity_error_q;
`endif

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 rx_valid_q, byte_strobe_q;
  logic [DATA_BITS-1:0] last_byte_q;
  logic                 overflow_q, frame_error_q;
  logic                 full_c, pop_c, push_c, drop_c;

  // Synchroniser and FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      sync1_q <= rx_serial;
      rxs_q   <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Next-state: bit timing counts from mid-start so every later sample lands mid-bit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_W'(HALF)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(LAST)) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxs_q;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_W'(LAST)) begin
          cnt_d     = '0;
          par_bad_d = ^{shift_q, rxs_q};
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_W'(LAST)) begin
          cnt_d   = '0;
          state_d = rxs_q ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame outcome events
  always_comb begin
    good_c = 1'b0;
    ferr_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_c = 1'b0;
`endif
    if (cnt_q == CNT_W'(LAST)) begin
      case (state_q)
        S_STOP: begin
          if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
            good_c = ~par_bad_q;
`else
            good_c = 1'b1;
`endif
          end else begin
            ferr_c = 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: perr_c = ^{shift_q, rxs_q};
`endif
        default: ;
      endcase
    end
  end

  // FIFO control: a pop frees the slot a full-FIFO push writes into
  always_comb begin
    full_c  = (count_q == CW'(FIFO_DEPTH));
    pop_c   = rx_valid_q & rx_ready;
    push_c  = good_c & (~full_c | pop_c);
    drop_c  = good_c & full_c & ~pop_c;
    count_d = count_q + CW'(push_c) - CW'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rx_valid_q    <= 1'b0;
      byte_strobe_q <= 1'b0;
      last_byte_q   <= '0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error_q <= 1'b0;
`endif
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q       <= count_d;
      rx_valid_q    <= (count_d != '0);
      byte_strobe_q <= good_c;
      if (good_c) last_byte_q <= shift_q;
      overflow_q    <= (overflow_q & ~err_clear) | drop_c;
      frame_error_q <= (frame_error_q & ~err_clear) | ferr_c;
`ifdef UART_RX_PARITY_EN
      parity_error_q <= (parity_error_q & ~err_clear) | perr_c;
`endif
    end
  end

  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_valid_q ? mem_q[rd_ptr_q] : '0;
  assign last_byte   = last_byte_q;
  assign byte_strobe = byte_strobe_q;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign frame_error = frame_error_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at CLKS_PER_BIT=16, 8 data bits, depth 16.
module tb_uart_rx_fifo;
  localparam int unsigned C     = 16;
  localparam int unsigned DB    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned H     = (C - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NB = DB + 3;
`else
  localparam int unsigned NB = DB + 2;
`endif
  localparam int unsigned S_OFF = 3 + H + (NB - 1) * C;

  logic       clk, reset, rx_serial, rx_ready, err_clear;
  logic       rx_valid, byte_strobe, overflow, frame_error, parity_error;
  logic [7:0] rx_data, last_byte;
  logic [4:0] fifo_count;

  uart_rx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx_serial(rx_serial), .rx_ready(rx_ready),
    .err_clear(err_clear), .rx_valid(rx_valid), .rx_data(rx_data),
    .last_byte(last_byte), .byte_strobe(byte_strobe), .fifo_count(fifo_count),
    .overflow(overflow), .frame_error(frame_error), .parity_error(parity_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int strobes = 0;
  int last_strobe_cyc = 0;
  logic [7:0] exp_strobe[$];
  logic [7:0] model[$];
  logic [7:0] mon_e;

  // Strobe scoreboard: each good frame's byte must appear on last_byte with the strobe
  always @(negedge clk) begin
    if (!reset && byte_strobe) begin
      strobes++;
      last_strobe_cyc = cyc;
      tests++;
      if (exp_strobe.size() == 0) begin
        fails++;
        $display("FAIL strobe_unexpected: last_byte=%h, no strobe expected", last_byte);
      end else begin
        mon_e = exp_strobe.pop_front();
        if (last_byte !== mon_e) begin
          fails++;
          $display("FAIL strobe_byte: last_byte=%h expected %h", last_byte, mon_e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  // Drives one whole frame; optionally asserts rx_ready exactly on the stop-sample edge
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip,
                            input logic pop_at_stop, output int t_start, output logic [7:0] popped);
    logic [NB-1:0] fr;
    logic good;
    fr = '0;
    fr[DB:1] = d;
`ifdef UART_RX_PARITY_EN
    fr[DB+1] = (^d) ^ par_flip;
`endif
    fr[NB-1] = stop_bit;
    good = stop_bit & ~par_flip;
    popped = 8'h00;
    if (good) exp_strobe.push_back(d);
    t_start = cyc;
    for (int i = 0; i < int'(NB * C); i++) begin
      rx_serial = fr[i / C];
      rx_ready  = pop_at_stop && (i == int'(S_OFF));
      if (rx_ready) popped = rx_data;
      @(posedge clk);
      #1;
    end
    rx_ready = 1'b0;
    if (good) begin
      if (model.size() < DEPTH) model.push_back(d);
      else if (pop_at_stop) begin
        void'(model.pop_front());
        model.push_back(d);
      end
    end
  endtask

  task automatic pop_one(output logic v, output logic [7:0] d);
    v = rx_valid;
    d = rx_data;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_errors();
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_serial = 1'b1; rx_ready = 1'b0; err_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({rx_valid, rx_data, last_byte, byte_strobe, fifo_count, overflow, frame_error, parity_error} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b data=%h last=%h strobe=%b count=%0d flags=%b%b%b expected all 0",
               rx_valid, rx_data, last_byte, byte_strobe, fifo_count, overflow, frame_error, parity_error);
    end
    reset = 1'b0;
    idle(4);
  endtask

  task automatic test_single_frame();
    int t0, s0;
    logic [7:0] pd, e;
    logic pv;
    s0 = strobes;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, t0, pd);
    tests++;
    if (strobes - s0 != 1) begin
      fails++; $display("FAIL single_strobe_count: got %0d expected 1", strobes - s0);
    end
    tests++;
    if (last_strobe_cyc != t0 + int'(S_OFF) + 1) begin
      fails++; $display("FAIL single_strobe_time: got cycle %0d expected %0d", last_strobe_cyc, t0 + int'(S_OFF) + 1);
    end
    tests++;
    if (last_byte !== 8'hA5 || rx_valid !== 1'b1 || rx_data !== 8'hA5 || fifo_count !== 5'd1) begin
      fails++; $display("FAIL single_state: last=%h valid=%b data=%h count=%0d expected A5 1 A5 1",
                        last_byte, rx_valid, rx_data, fifo_count);
    end
    tests++;
    if ({overflow, frame_error, parity_error} !== 3'b000) begin
      fails++; $display("FAIL single_flags: got %b%b%b expected 000", overflow, frame_error, parity_error);
    end
    e = model.pop_front();
    pop_one(pv, pd);
    tests++;
    if (pv !== 1'b1 || pd !== e) begin
      fails++; $display("FAIL single_pop: valid=%b data=%h expected 1 %h", pv, pd, e);
    end
    tests++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00 || fifo_count !== 5'd0) begin
      fails++; $display("FAIL single_empty: valid=%b data=%h count=%0d expected 0 00 0", rx_valid, rx_data, fifo_count);
    end
  endtask

  task automatic test_overflow();
    int t0;
    logic [7:0] pd, e;
    logic pv;
    for (int k = 0; k <= int'(DEPTH); k++) send_frame(8'(k), 1'b1, 1'b0, 1'b0, t0, pd);
    tests++;
    if (fifo_count !== 5'd16 || overflow !== 1'b1 || last_byte !== 8'h10) begin
      fails++; $display("FAIL ovf_state: count=%0d ovf=%b last=%h expected 16 1 10", fifo_count, overflow, last_byte);
    end
    for (int k = 0; k < int'(DEPTH); k++) begin
      e = model.pop_front();
      pop_one(pv, pd);
      tests++;
      if (pv !== 1'b1 || pd !== e || e !== 8'(k)) begin
        fails++; $display("FAIL ovf_pop%0d: valid=%b data=%h expected 1 %h", k, pv, pd, 8'(k));
      end
    end
    tests++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      fails++; $display("FAIL ovf_drained: valid=%b data=%h expected 0 00", rx_valid, rx_data);
    end
    clear_errors();
    tests++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL ovf_clear: overflow=%b expected 0", overflow);
    end
  endtask

  task automatic test_frame_error();
    int t0;
    logic [7:0] pd, e;
    logic pv;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, t0, pd);
    rx_serial = 1'b0;
    repeat (5 * C) @(posedge clk);
    #1;
    idle(2 * C);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, t0, pd);
    tests++;
    if (frame_error !== 1'b1 || fifo_count !== 5'd1 || rx_data !== 8'h3C) begin
      fails++; $display("FAIL ferr_state: ferr=%b count=%0d data=%h expected 1 1 3C", frame_error, fifo_count, rx_data);
    end
    e = model.pop_front();
    pop_one(pv, pd);
    tests++;
    if (pv !== 1'b1 || pd !== e) begin
      fails++; $display("FAIL ferr_pop: valid=%b data=%h expected 1 %h", pv, pd, e);
    end
    clear_errors();
    tests++;
    if (frame_error !== 1'b0) begin
      fails++; $display("FAIL ferr_clear: frame_error=%b expected 0", frame_error);
    end
  endtask

  task automatic test_glitch();
    int t0, s0;
    logic [7:0] pd, e;
    logic pv;
    s0 = strobes;
    rx_serial = 1'b0;
    repeat (C / 4) @(posedge clk);
    #1;
    idle(3 * C);
    tests++;
    if (strobes != s0 || fifo_count !== 5'd0 || {overflow, frame_error, parity_error} !== 3'b000) begin
      fails++; $display("FAIL glitch_quiet: strobes=%0d count=%0d flags=%b%b%b expected 0 0 000",
                        strobes - s0, fifo_count, overflow, frame_error, parity_error);
    end
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, t0, pd);
    e = model.pop_front();
    pop_one(pv, pd);
    tests++;
    if (pv !== 1'b1 || pd !== e) begin
      fails++; $display("FAIL glitch_after: valid=%b data=%h expected 1 %h", pv, pd, e);
    end
  endtask

  task automatic test_full_with_pop();
    int t0;
    logic [7:0] pd, e;
    logic pv;
    for (int k = 0; k < int'(DEPTH); k++) send_frame(8'h20 + 8'(k), 1'b1, 1'b0, 1'b0, t0, pd);
    send_frame(8'h30, 1'b1, 1'b0, 1'b1, t0, pd);
    tests++;
    if (pd !== 8'h20) begin
      fails++; $display("FAIL fullpop_head: popped=%h expected 20", pd);
    end
    tests++;
    if (fifo_count !== 5'd16 || overflow !== 1'b0) begin
      fails++; $display("FAIL fullpop_state: count=%0d ovf=%b expected 16 0", fifo_count, overflow);
    end
    for (int k = 0; k < int'(DEPTH); k++) begin
      e = model.pop_front();
      pop_one(pv, pd);
      tests++;
      if (pv !== 1'b1 || pd !== e || e !== 8'h21 + 8'(k)) begin
        fails++; $display("FAIL fullpop_pop%0d: valid=%b data=%h expected 1 %h", k, pv, pd, 8'h21 + 8'(k));
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int t0, s0;
    logic [7:0] pd;
    s0 = strobes;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, t0, pd);
    tests++;
    if (parity_error !== 1'b1 || fifo_count !== 5'd0 || strobes != s0) begin
      fails++; $display("FAIL parity_bad: perr=%b count=%0d strobes=%0d expected 1 0 0",
                        parity_error, fifo_count, strobes - s0);
    end
    clear_errors();
    tests++;
    if (parity_error !== 1'b0) begin
      fails++; $display("FAIL parity_clear: parity_error=%b expected 0", parity_error);
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int t0;
    logic [7:0] pd, e;
    logic pv;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, t0, pd);
    rx_serial = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    tests++;
    if ({rx_valid, rx_data, last_byte, fifo_count, overflow, frame_error, parity_error} !== '0) begin
      fails++; $display("FAIL midreset_async: valid=%b data=%h last=%h count=%0d expected all 0",
                        rx_valid, rx_data, last_byte, fifo_count);
    end
    model.delete();
    rx_serial = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2 * C);
    send_frame(8'h42, 1'b1, 1'b0, 1'b0, t0, pd);
    tests++;
    if (fifo_count !== 5'd1 || frame_error !== 1'b0) begin
      fails++; $display("FAIL midreset_count: count=%0d ferr=%b expected 1 0", fifo_count, frame_error);
    end
    e = model.pop_front();
    pop_one(pv, pd);
    tests++;
    if (pv !== 1'b1 || pd !== e) begin
      fails++; $display("FAIL midreset_pop: valid=%b data=%h expected 1 %h", pv, pd, e);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_frame_error();
    test_glitch();
    test_full_with_pop();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    idle(4);
    tests++;
    if (exp_strobe.size() != 0) begin
      fails++; $display("FAIL strobes_missing: %0d expected strobes never seen", exp_strobe.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
